// File: rtl/fp32_maxmin_stream.sv
// Streaming FP32 max/min finder: reduces masked lanes of each beat, accumulates
// across a frame, and holds the extrema with their element indices until consumed.
module fp32_maxmin_stream #(
  parameter int LANES    = 4,
  parameter int IDX_W    = 16,
  parameter int ABS_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*32-1:0]   in_data,
  input  logic [LANES-1:0]      in_mask,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           max_value,
  output logic [31:0]           min_value,
  output logic [IDX_W-1:0]      max_index,
  output logic [IDX_W-1:0]      min_index,
  output logic                  nan_seen,
  output logic                  empty_frame
);

  typedef enum logic [0:0] {ACCUM, HOLD} state_t;

  localparam int SW = IDX_W + 5;
  localparam logic [SW-1:0] IDX_MAX = SW'({IDX_W{1'b1}});
  localparam logic [31:0]   QNAN    = 32'h7FC0_0000;

  // Keys turn IEEE ordering into plain unsigned ordering (-0 sorts below +0).
  function automatic logic [31:0] to_key(input logic [31:0] v);
    return v[31] ? ~v : (v | 32'h8000_0000);
  endfunction

  function automatic logic [31:0] from_key(input logic [31:0] k);
    return k[31] ? (k & 32'h7FFF_FFFF) : ~k;
  endfunction

  state_t             state_q;
  logic               acc_has_q, acc_nan_q;
  logic [31:0]        acc_max_key_q, acc_min_key_q;
  logic [IDX_W-1:0]   acc_max_idx_q, acc_min_idx_q;
  logic [IDX_W-1:0]   base_q;
  logic               base_sat_q;

  logic               accept;
  logic [31:0]        lane_v, lane_k;
  logic               lane_nan;
  logic [SW-1:0]      lane_sum;
  logic [IDX_W-1:0]   lane_idx;
  logic               b_has, b_nan;
  logic [31:0]        b_max_key, b_min_key;
  logic [IDX_W-1:0]   b_max_idx, b_min_idx;
  logic               m_has, m_nan;
  logic [31:0]        m_max_key, m_min_key;
  logic [IDX_W-1:0]   m_max_idx, m_min_idx;
  logic [SW-1:0]      base_sum;
  logic               base_next_sat;

  // HOLD hands the ready decision to the consumer so a new frame can start on the drain edge.
  assign in_ready = !rst && ((state_q == ACCUM) || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    // NOTE: every variable gets a default before the loop so no path infers a latch.
    lane_v    = '0;
    lane_k    = '0;
    lane_nan  = 1'b0;
    lane_sum  = '0;
    lane_idx  = '0;
    b_has     = 1'b0;
    b_nan     = 1'b0;
    b_max_key = '0;
    b_min_key = '0;
    b_max_idx = '0;
    b_min_idx = '0;
    // Lanes scanned upward with strict compares, so ties keep the lower index.
    for (int k = 0; k < LANES; k++) begin
      lane_v = in_data[32*k +: 32];
      if (ABS_MODE != 0) lane_v[31] = 1'b0;
      lane_nan = (&lane_v[30:23]) && (|lane_v[22:0]);
      lane_k   = to_key(lane_v);
      lane_sum = SW'(base_q) + SW'(k);
      lane_idx = (base_sat_q || lane_sum > IDX_MAX) ? '1 : lane_sum[IDX_W-1:0];
      if (in_mask[k]) begin
        if (lane_nan) begin
          b_nan = 1'b1;
        end else begin
          if (!b_has || lane_k > b_max_key) begin
            b_max_key = lane_k;
            b_max_idx = lane_idx;
          end
          if (!b_has || lane_k < b_min_key) begin
            b_min_key = lane_k;
            b_min_idx = lane_idx;
          end
          b_has = 1'b1;
        end
      end
    end
  end

  // Accumulator holds earlier indices, so the beat only wins on a strict improvement.
  always_comb begin
    m_has     = acc_has_q | b_has;
    m_nan     = acc_nan_q | b_nan;
    m_max_key = acc_max_key_q;
    m_max_idx = acc_max_idx_q;
    m_min_key = acc_min_key_q;
    m_min_idx = acc_min_idx_q;
    if (b_has && (!acc_has_q || b_max_key > acc_max_key_q)) begin
      m_max_key = b_max_key;
      m_max_idx = b_max_idx;
    end
    if (b_has && (!acc_has_q || b_min_key < acc_min_key_q)) begin
      m_min_key = b_min_key;
      m_min_idx = b_min_idx;
    end
    base_sum      = SW'(base_q) + SW'(LANES);
    base_next_sat = base_sat_q || (base_sum > IDX_MAX);
  end

  // NOTE: state uses non-blocking assignments; later assignments in the block take priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ACCUM;
      out_valid     <= 1'b0;
      max_value     <= '0;
      min_value     <= '0;
      max_index     <= '0;
      min_index     <= '0;
      nan_seen      <= 1'b0;
      empty_frame   <= 1'b0;
      acc_has_q     <= 1'b0;
      acc_nan_q     <= 1'b0;
      acc_max_key_q <= '0;
      acc_min_key_q <= '0;
      acc_max_idx_q <= '0;
      acc_min_idx_q <= '0;
      base_q        <= '0;
      base_sat_q    <= 1'b0;
    end else begin
      if (state_q == HOLD && out_ready) begin
        state_q   <= ACCUM;
        out_valid <= 1'b0;
      end
      if (accept) begin
        if (in_last) begin
          state_q     <= HOLD;
          out_valid   <= 1'b1;
          nan_seen    <= m_nan;
          empty_frame <= !m_has;
          max_value   <= m_has ? from_key(m_max_key) : QNAN;
          min_value   <= m_has ? from_key(m_min_key) : QNAN;
          max_index   <= m_has ? m_max_idx : '0;
          min_index   <= m_has ? m_min_idx : '0;
          // Clear the accumulator now so the next accepted beat starts a fresh frame.
          acc_has_q     <= 1'b0;
          acc_nan_q     <= 1'b0;
          acc_max_key_q <= '0;
          acc_min_key_q <= '0;
          acc_max_idx_q <= '0;
          acc_min_idx_q <= '0;
          base_q        <= '0;
          base_sat_q    <= 1'b0;
        end else begin
          acc_has_q     <= m_has;
          acc_nan_q     <= m_nan;
          acc_max_key_q <= m_max_key;
          acc_min_key_q <= m_min_key;
          acc_max_idx_q <= m_max_idx;
          acc_min_idx_q <= m_min_idx;
          base_q        <= base_sum[IDX_W-1:0];
          base_sat_q    <= base_next_sat;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp32_maxmin_stream.sv
// Directed bench for fp32_maxmin_stream: default, magnitude-mode and narrow-index
// instances share one stimulus stream; expected values are hand-derived constants.
module tb_fp32_maxmin_stream;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_last, out_ready;
  logic [127:0] in_data;
  logic [3:0]   in_mask;

  logic         in_ready, out_valid, nan_seen, empty_frame;
  logic [31:0]  max_value, min_value;
  logic [15:0]  max_index, min_index;

  logic         a_in_ready, a_out_valid, a_nan_seen, a_empty_frame;
  logic [31:0]  a_max_value, a_min_value;
  logic [15:0]  a_max_index, a_min_index;

  logic         s_in_ready, s_out_valid, s_nan_seen, s_empty_frame;
  logic [31:0]  s_max_value, s_min_value;
  logic [2:0]   s_max_index, s_min_index;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp32_maxmin_stream #(.LANES(4), .IDX_W(16), .ABS_MODE(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mask(in_mask), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .max_value(max_value), .min_value(min_value),
    .max_index(max_index), .min_index(min_index),
    .nan_seen(nan_seen), .empty_frame(empty_frame)
  );

  fp32_maxmin_stream #(.LANES(4), .IDX_W(16), .ABS_MODE(1)) dut_abs (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_mask(in_mask), .in_last(in_last),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .max_value(a_max_value), .min_value(a_min_value),
    .max_index(a_max_index), .min_index(a_min_index),
    .nan_seen(a_nan_seen), .empty_frame(a_empty_frame)
  );

  fp32_maxmin_stream #(.LANES(4), .IDX_W(3), .ABS_MODE(0)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .in_mask(in_mask), .in_last(in_last),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .max_value(s_max_value), .min_value(s_min_value),
    .max_index(s_max_index), .min_index(s_min_index),
    .nan_seen(s_nan_seen), .empty_frame(s_empty_frame)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pack4(input logic [31:0] l0, input logic [31:0] l1,
                                         input logic [31:0] l2, input logic [31:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  // Presents one beat just after a falling edge and returns at the next falling edge.
  task automatic send(input logic [127:0] data, input logic [3:0] mask, input logic last);
    in_valid = 1'b1;
    in_data  = data;
    in_mask  = mask;
    in_last  = last;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_drained_valid"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    in_data = '0; in_mask = '0;
    #12;
    check("rst_in_ready",  {31'd0, in_ready},    32'd0);
    check("rst_out_valid", {31'd0, out_valid},   32'd0);
    check("rst_max_value", max_value,            32'd0);
    check("rst_min_index", {16'd0, min_index},   32'd0);
    check("rst_empty",     {31'd0, empty_frame}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Single beat {1,-1,2,-2}
    send(pack4(32'h3F800000, 32'hBF800000, 32'h40000000, 32'hC0000000), 4'hF, 1'b1);
    check("v1_out_valid", {31'd0, out_valid},   32'd1);
    check("v1_max_value", max_value,            32'h40000000);
    check("v1_max_index", {16'd0, max_index},   32'd2);
    check("v1_min_value", min_value,            32'hC0000000);
    check("v1_min_index", {16'd0, min_index},   32'd3);
    check("v1_nan_seen",  {31'd0, nan_seen},    32'd0);
    check("v1_empty",     {31'd0, empty_frame}, 32'd0);
    check("v1_hold_ready", {31'd0, in_ready},   32'd0);
    drain("v1");

    // Two beats, masked NaN lane, tie between +1.0 at indices 2 and 4
    send(pack4(32'h80000000, 32'h00000000, 32'h3F800000, 32'h7FC00000), 4'h7, 1'b0);
    check("v2_mid_valid", {31'd0, out_valid}, 32'd0);
    check("v2_mid_ready", {31'd0, in_ready},  32'd1);
    send(pack4(32'h3F800000, 32'hFF800000, 32'h00000000, 32'h00000000), 4'h7, 1'b1);
    check("v2_max_value", max_value,          32'h3F800000);
    check("v2_max_index", {16'd0, max_index}, 32'd2);
    check("v2_min_value", min_value,          32'hFF800000);
    check("v2_min_index", {16'd0, min_index}, 32'd5);
    check("v2_nan_seen",  {31'd0, nan_seen},  32'd0);
    drain("v2");

    // All lanes NaN
    send({4{32'h7FC00001}}, 4'hF, 1'b1);
    check("v3_max_value", max_value,            32'h7FC00000);
    check("v3_min_value", min_value,            32'h7FC00000);
    check("v3_max_index", {16'd0, max_index},   32'd0);
    check("v3_empty",     {31'd0, empty_frame}, 32'd1);
    check("v3_nan_seen",  {31'd0, nan_seen},    32'd1);
    drain("v3");

    // Fully masked beat: empty without NaN
    send({4{32'h7FC00001}}, 4'h0, 1'b1);
    check("v4_empty",    {31'd0, empty_frame}, 32'd1);
    check("v4_nan_seen", {31'd0, nan_seen},    32'd0);
    drain("v4");

    // Single element frame
    send(pack4(32'hBF800000, 32'h40000000, 32'h40000000, 32'h40000000), 4'h1, 1'b1);
    check("v5_max_value", max_value,          32'hBF800000);
    check("v5_min_value", min_value,          32'hBF800000);
    check("v5_max_index", {16'd0, max_index}, 32'd0);
    check("v5_min_index", {16'd0, min_index}, 32'd0);
    drain("v5");

    // Signed zeros: -0 orders below +0
    send(pack4(32'h00000000, 32'h80000000, 32'h3F800000, 32'h3F800000), 4'h3, 1'b1);
    check("v6_max_value", max_value,          32'h00000000);
    check("v6_max_index", {16'd0, max_index}, 32'd0);
    check("v6_min_value", min_value,          32'h80000000);
    check("v6_min_index", {16'd0, min_index}, 32'd1);
    drain("v6");

    // Three beats: narrow-index instance saturates from element 8 onward
    send({4{32'h3F800000}}, 4'hF, 1'b0);
    send({4{32'h3F800000}}, 4'hF, 1'b0);
    send(pack4(32'h40A00000, 32'h3F800000, 32'h3F800000, 32'hBF800000), 4'hF, 1'b1);
    check("v7_max_index",   {16'd0, max_index},   32'd8);
    check("v7_min_index",   {16'd0, min_index},   32'd11);
    check("v7_sat_max_val", s_max_value,          32'h40A00000);
    check("v7_sat_max_idx", {29'd0, s_max_index}, 32'd7);
    check("v7_sat_min_val", s_min_value,          32'hBF800000);
    check("v7_sat_min_idx", {29'd0, s_min_index}, 32'd7);
    drain("v7");

    // Magnitude mode {-3,2,-0.5,1}; result then held for the backpressure test
    send(pack4(32'hC0400000, 32'h40000000, 32'hBF000000, 32'h3F800000), 4'hF, 1'b1);
    check("v8_abs_max_value", a_max_value,          32'h40400000);
    check("v8_abs_max_index", {16'd0, a_max_index}, 32'd0);
    check("v8_abs_min_value", a_min_value,          32'h3F000000);
    check("v8_abs_min_index", {16'd0, a_min_index}, 32'd2);
    check("v8_max_value",     max_value,            32'h40000000);
    check("v8_min_value",     min_value,            32'hC0400000);

    // Backpressure: a pending beat is refused while out_ready stays low
    in_valid = 1'b1;
    in_data  = pack4(32'h40800000, 32'h3F800000, 32'h3F800000, 32'hC0000000);
    in_mask  = 4'hF;
    in_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("v9_hold_valid", {31'd0, out_valid},  32'd1);
      check("v9_hold_ready", {31'd0, in_ready},   32'd0);
      check("v9_hold_max",   max_value,           32'h40000000);
      check("v9_hold_idx",   {16'd0, max_index},  32'd1);
    end
    out_ready = 1'b1;
    #1;
    check("v9_pass_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    check("v9_new_valid",     {31'd0, out_valid},  32'd1);
    check("v9_new_max_value", max_value,           32'h40800000);
    check("v9_new_max_index", {16'd0, max_index},  32'd0);
    check("v9_new_min_value", min_value,           32'hC0000000);
    check("v9_new_min_index", {16'd0, min_index},  32'd3);
    drain("v9");

    // Reset in the middle of a frame discards the partial beat
    send({4{32'h41100000}}, 4'hF, 1'b0);
    rst = 1'b1;
    #2;
    check("v10_rst_ready", {31'd0, in_ready},  32'd0);
    check("v10_rst_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("v10_post_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    check("v10_no_stale", {31'd0, out_valid}, 32'd0);
    send(pack4(32'h3F800000, 32'h3F000000, 32'h3F000000, 32'h3F000000), 4'hF, 1'b1);
    check("v10_valid",     {31'd0, out_valid},  32'd1);
    check("v10_max_value", max_value,           32'h3F800000);
    check("v10_max_index", {16'd0, max_index},  32'd0);
    check("v10_min_value", min_value,           32'h3F000000);
    check("v10_min_index", {16'd0, min_index},  32'd1);
    drain("v10");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp32_maxmin_stream.md
FP32_MAXMIN_STREAM -- requirements
Module: fp32_maxmin_stream

Interface
REQ-001 Parameter LANES, default 4, FP32 elements per input beat (1..16).
REQ-002 Parameter IDX_W, default 16, width of element index outputs.
REQ-003 Parameter ABS_MODE, default 0; 1 = compare magnitudes, report values with sign bit cleared.
REQ-004 Ports SHALL be, clock and reset first:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  beat present.
- in_ready  output  1  beat accepted when in_valid && in_ready at clk rise.
- in_data  input  LANES*32  lane k at bits [32k+31:32k].
- in_mask  input  LANES  lane k participates when 1.
- in_last  input  1  beat closes the frame.
- out_valid  output  1  frame result held.
- out_ready  input  1  result consumed when out_valid && out_ready at clk rise.
- max_value, min_value  output  32  frame extrema.
- max_index, min_index  output  IDX_W  element index of the extrema.
- nan_seen  output  1  at least one masked-in NaN in frame.
- empty_frame  output  1  no masked-in non-NaN element in frame.

Function
REQ-005 Element index = beat_number*LANES + lane; beat_number restarts at 0 on each frame's first accepted beat.
REQ-006 Ordering via unsigned compare of key: sign=1 -> ~bits, sign=0 -> bits|0x80000000; -0 < +0; +/-Inf ordered normally.
REQ-007 ABS_MODE=1: sign bit cleared before keying; outputs never carry sign=1.
REQ-008 NaN (exp=0xFF, mantissa!=0) excluded from comparison; sets nan_seen.
REQ-009 Ties: lowest element index wins, for both max and min.
REQ-010 Masked-out lanes ignored completely, including NaN detection.
REQ-011 Per-beat lane reduction combinational; frame accumulator updated on each accepted beat.
REQ-012 FSM states ACCUM and HOLD; reset enters ACCUM.
REQ-013 ACCUM: in_ready=1, out_valid=0; accepted beat with in_last=1 -> HOLD, result registered at that same edge.
REQ-014 Latency: out_valid high the cycle after the in_last beat's accepting edge.
REQ-015 HOLD: out_valid=1, outputs stable, in_ready=out_ready.
REQ-016 HOLD with out_ready=1 and no beat accepted -> ACCUM, out_valid low next cycle.
REQ-017 HOLD with out_ready=1 and beat accepted: beat is index-0 beat of a new frame; in_last=1 on it -> remain HOLD with new result next cycle; otherwise -> ACCUM.
REQ-018 Empty frame (every element masked out or NaN): max_value=min_value=0x7FC00000, indices 0, empty_frame=1.
REQ-019 Element index saturates at all-ones of IDX_W; index of any element beyond reports all-ones; comparison continues.
REQ-020 Single-element frame: max=min=that element, both indices equal.

Reset
REQ-021 rst asserted: asynchronously in_ready=0, out_valid=0, max_value=min_value=0, indices 0, nan_seen=0, empty_frame=0, state ACCUM, partial frame discarded.
REQ-022 First cycle after rst deassertion: in_ready=1; no result of a frame interrupted by reset ever appears.

Verification
REQ-023 LANES=4, one beat {1.0,-1.0,2.0,-2.0}, mask 0xF, last -> max 0x40000000 idx 2, min 0xC0000000 idx 3, out_valid next cycle.
REQ-024 Two beats {0x80000000,0,0x3F800000,0x7FC00000} then {0x3F800000,0xFF800000,0,0} mask 0x7 -> max 0x3F800000 idx 2 (tie, lower), min 0xFF800000 idx 5, nan_seen=0 (NaN lane masked).
REQ-025 All lanes 0x7FC00001, mask 0xF, last -> max=min=0x7FC00000, empty_frame=1, nan_seen=1.
REQ-026 ABS_MODE=1, {-3.0,2.0,-0.5,1.0} -> max 0x40400000 idx 0, min 0x3F000000 idx 2.
REQ-027 HOLD with out_ready=0 three cycles then out_ready=1 with a valid last beat {4.0,...} same cycle -> outputs stable over hold, in_ready=0 during it, new result max 0x40800000 next cycle.
REQ-028 rst pulse mid-frame after one non-last beat, then one last beat {1.0,...} -> result reflects only post-reset beat, indices start at 0.
